// File: rtl/ext_unit.sv
// ext_unit: zero/sign extension of an IN_W-bit field to OUT_W bits.
// dout is the combinational result of the current din/ext_op; dout_q/out_valid
// capture that result one cycle after an in_valid cycle. rst is synchronous,
// active-high, and wins over a simultaneous in_valid.
module ext_unit #(
   parameter int IN_W  = 1,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ext_op,
   input  logic [IN_W-1:0]  din,
   input  logic             in_valid,
   output logic [OUT_W-1:0] dout,
   output logic [OUT_W-1:0] dout_q,
   output logic             out_valid
);

   // Extension logic; the equal-width case has no upper field to fill.
   generate
      if (OUT_W < IN_W) begin : g_bad_width
         $error("ext_unit: OUT_W (%0d) must not be smaller than IN_W (%0d)", OUT_W, IN_W);
      end else if (OUT_W == IN_W) begin : g_same_width
         assign dout = din;
      end else begin : g_extend
         logic fill_bit;
         assign fill_bit = ext_op & din[IN_W-1];
         assign dout     = {{(OUT_W-IN_W){fill_bit}}, din};
      end
   endgenerate

   // Capture the extended value on valid cycles; out_valid marks a fresh result.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q    <= '0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         dout_q    <= dout;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ext_unit.sv
// Bench for ext_unit: three instances (1->32, 16->32, 8->8) checked against an
// arithmetic model of zero/sign extension and a cycle model of the capture register.
module tb_ext_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;

   logic        op1 = 1'b0;
   logic [0:0]  din1 = '0;
   logic [31:0] dout1, dout_q1;
   logic        ov1;

   logic        op16 = 1'b0;
   logic [15:0] din16 = '0;
   logic [31:0] dout16, dout_q16;
   logic        ov16;

   logic        op8 = 1'b0;
   logic [7:0]  din8 = '0;
   logic [7:0]  dout8, dout_q8;
   logic        ov8;

   int errors = 0;
   int checks = 0;

   logic [63:0] exp_q16 = '0;
   logic [63:0] exp_q8  = '0;
   logic        exp_v   = 1'b0;

   always #5 clk = ~clk;

   ext_unit #(.IN_W(1), .OUT_W(32)) dut1 (
      .clk(clk), .rst(rst), .ext_op(op1), .din(din1), .in_valid(in_valid),
      .dout(dout1), .dout_q(dout_q1), .out_valid(ov1));

   ext_unit #(.IN_W(16), .OUT_W(32)) dut16 (
      .clk(clk), .rst(rst), .ext_op(op16), .din(din16), .in_valid(in_valid),
      .dout(dout16), .dout_q(dout_q16), .out_valid(ov16));

   ext_unit #(.IN_W(8), .OUT_W(8)) dut8 (
      .clk(clk), .rst(rst), .ext_op(op8), .din(din8), .in_valid(in_valid),
      .dout(dout8), .dout_q(dout_q8), .out_valid(ov8));

   // Numeric meaning of extension: a sign-extended negative value is d - 2^in_w,
   // represented modulo 2^out_w, i.e. d + 2^out_w - 2^in_w.
   function automatic logic [63:0] ref_ext(logic [63:0] d, int in_w, int out_w, bit op);
      logic [63:0] half;
      half = 64'd1 << (in_w - 1);
      if (op && d >= half)
         return d + ((64'd1 << out_w) - (64'd1 << in_w));
      return d;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: advance the register model with the inputs present at the edge.
   task automatic step();
      logic r, v;
      logic [63:0] e16, e8;
      r   = rst;
      v   = in_valid;
      e16 = ref_ext(64'(din16), 16, 32, op16);
      e8  = ref_ext(64'(din8), 8, 8, op8);
      @(posedge clk);
      if (r) begin
         exp_q16 = '0; exp_q8 = '0; exp_v = 1'b0;
      end else if (v) begin
         exp_q16 = e16; exp_q8 = e8; exp_v = 1'b1;
      end else begin
         exp_v = 1'b0;
      end
      #1;
   endtask

   task automatic chk_reg(string tag);
      chk({tag, "_q16"}, 64'(dout_q16), exp_q16);
      chk({tag, "_v16"}, 64'(ov16), 64'(exp_v));
      chk({tag, "_q8"},  64'(dout_q8), exp_q8);
      chk({tag, "_v8"},  64'(ov8), 64'(exp_v));
   endtask

   initial begin
      // Reset state
      rst = 1'b1; in_valid = 1'b1; din16 = 16'hABCD; op16 = 1'b1;
      step();
      chk("rst_q16", 64'(dout_q16), 64'h0);
      chk("rst_v16", 64'(ov16), 64'h0);
      chk("rst_q1", 64'(dout_q1), 64'h0);
      chk("rst_v1", 64'(ov1), 64'h0);
      rst = 1'b0; in_valid = 1'b0;

      // 1-bit field into 32 bits
      op1 = 1'b0; din1 = 1'b0; #1 chk("w1_z0", 64'(dout1), 64'h0000_0000);
      op1 = 1'b0; din1 = 1'b1; #1 chk("w1_z1", 64'(dout1), 64'h0000_0001);
      op1 = 1'b1; din1 = 1'b1; #1 chk("w1_s1", 64'(dout1), 64'hFFFF_FFFF);
      op1 = 1'b1; din1 = 1'b0; #1 chk("w1_s0", 64'(dout1), 64'h0000_0000);

      // 16-bit field into 32 bits
      op16 = 1'b1; din16 = 16'h8000; #1 chk("w16_s8000", 64'(dout16), 64'hFFFF_8000);
      op16 = 1'b0; din16 = 16'h8000; #1 chk("w16_z8000", 64'(dout16), 64'h0000_8000);
      op16 = 1'b1; din16 = 16'h7FFF; #1 chk("w16_s7fff", 64'(dout16), 64'h0000_7FFF);

      // Equal widths pass straight through
      op8 = 1'b0; din8 = 8'h80; #1 chk("w8_z80", 64'(dout8), 64'h80);
      op8 = 1'b1; din8 = 8'h80; #1 chk("w8_s80", 64'(dout8), 64'h80);

      // Single capture then hold with cleared valid while inputs wander
      in_valid = 1'b1; op16 = 1'b1; din16 = 16'h8001;
      step();
      chk("cap_q", 64'(dout_q16), 64'hFFFF_8001);
      chk("cap_v", 64'(ov16), 64'h1);
      in_valid = 1'b0; op16 = 1'b0; din16 = 16'h1111;
      step();
      chk("hold_q", 64'(dout_q16), 64'hFFFF_8001);
      chk("hold_v", 64'(ov16), 64'h0);

      // Back-to-back stream
      in_valid = 1'b1; op16 = 1'b1; din16 = 16'h0001;
      step();
      chk("str0_q", 64'(dout_q16), 64'h0000_0001); chk("str0_v", 64'(ov16), 64'h1);
      din16 = 16'hFFFF;
      step();
      chk("str1_q", 64'(dout_q16), 64'hFFFF_FFFF); chk("str1_v", 64'(ov16), 64'h1);
      din16 = 16'h1234;
      step();
      chk("str2_q", 64'(dout_q16), 64'h0000_1234); chk("str2_v", 64'(ov16), 64'h1);

      // Reset wins over a simultaneous valid; dout stays combinational
      rst = 1'b1; in_valid = 1'b1; din16 = 16'hFFFF; op16 = 1'b1;
      #1 chk("rstpri_dout", 64'(dout16), 64'hFFFF_FFFF);
      step();
      chk("rstpri_q", 64'(dout_q16), 64'h0);
      chk("rstpri_v", 64'(ov16), 64'h0);
      chk("rstpri_dout2", 64'(dout16), 64'hFFFF_FFFF);
      rst = 1'b0;
      step();
      chk_reg("post_rst");

      // Randomized traffic against the models
      for (int i = 0; i < 300; i++) begin
         rst      = ($urandom_range(0, 15) == 0);
         in_valid = $urandom_range(0, 1);
         op1      = $urandom_range(0, 1);
         din1     = 1'($urandom_range(0, 1));
         op16     = $urandom_range(0, 1);
         din16    = 16'($urandom_range(0, 65535));
         op8      = $urandom_range(0, 1);
         din8     = 8'($urandom_range(0, 255));
         #1;
         chk("rnd_d1",  64'(dout1),  ref_ext(64'(din1), 1, 32, op1));
         chk("rnd_d16", 64'(dout16), ref_ext(64'(din16), 16, 32, op16));
         chk("rnd_d8",  64'(dout8),  ref_ext(64'(din8), 8, 8, op8));
         step();
         chk_reg("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop in case the sequence above ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ext_unit.md
EXT_UNIT -- requirements
Module: ext_unit

Interface
REQ-001 SHALL have parameter IN_W, default 1: width of the input field to extend.
REQ-002 SHALL have parameter OUT_W, default 32: width of the extended result; positional parameter order SHALL be (IN_W, OUT_W).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port ext_op, input, 1: extension mode; 1 = sign-extend, 0 = zero-extend.
REQ-006 SHALL have port din, input, IN_W: value to extend.
REQ-007 SHALL have port in_valid, input, 1: din/ext_op qualify for capture this cycle.
REQ-008 SHALL have port dout, output, OUT_W: combinational extended value of the current din/ext_op.
REQ-009 SHALL have port dout_q, output, OUT_W: registered extended value.
REQ-010 SHALL have port out_valid, output, 1: dout_q holds a result captured on the previous valid cycle.

Function
REQ-011 dout[IN_W-1:0] SHALL equal din.
REQ-012 dout[OUT_W-1:IN_W] SHALL be all copies of din[IN_W-1] when ext_op=1, and all zeros when ext_op=0.
REQ-013 With IN_W=1, sign-extension SHALL replicate the single input bit; (ext_op=1, din=1) gives all ones.
REQ-014 When OUT_W equals IN_W, dout SHALL equal din for either ext_op.
REQ-015 OUT_W smaller than IN_W SHALL be rejected at elaboration.
REQ-016 dout SHALL be purely combinational, with no dependence on clk, rst or in_valid.
REQ-017 On a rising edge with rst=0 and in_valid=1, dout_q SHALL load the dout value and out_valid SHALL be set to 1 (latency 1 cycle).
REQ-018 On a rising edge with rst=0 and in_valid=0, dout_q SHALL hold its value and out_valid SHALL be cleared to 0.
REQ-019 No backpressure: every valid input SHALL be accepted; back-to-back valid cycles SHALL produce back-to-back results.
REQ-020 Changes to ext_op or din while in_valid=0 SHALL NOT affect dout_q.

Reset
REQ-021 On a rising edge with rst=1, dout_q SHALL become 0 and out_valid SHALL become 0, regardless of in_valid.
REQ-022 rst=1 SHALL take priority over a simultaneous in_valid=1; that input is discarded.
REQ-023 dout SHALL remain combinationally correct while rst is asserted.
REQ-024 A reset asserted mid-stream SHALL leave no stale result: out_valid=0 on the cycle after the reset edge.

Verification
REQ-025 IN_W=1, OUT_W=32, combinational outputs:
  - ext_op=0, din=0 -> dout=0x00000000
  - ext_op=0, din=1 -> dout=0x00000001
  - ext_op=1, din=1 -> dout=0xFFFFFFFF
  - ext_op=1, din=0 -> dout=0x00000000
REQ-026 IN_W=16, OUT_W=32, combinational outputs:
  - ext_op=1, din=0x8000 -> dout=0xFFFF8000
  - ext_op=0, din=0x8000 -> dout=0x00008000
  - ext_op=1, din=0x7FFF -> dout=0x00007FFF
REQ-027 Registered path, IN_W=16: in_valid=1 with ext_op=1, din=0x8001 -> next cycle dout_q=0xFFFF8001, out_valid=1; following cycle in_valid=0 -> dout_q holds 0xFFFF8001, out_valid=0.
REQ-028 Streaming: din values 0x0001, 0xFFFF, 0x1234 on three consecutive valid cycles with ext_op=1 -> dout_q on the following three cycles is 0x00000001, 0xFFFFFFFF, 0x00001234, with out_valid=1 throughout.
REQ-029 Reset priority: rst=1 and in_valid=1 (din=0xFFFF, ext_op=1) in the same cycle -> dout_q=0, out_valid=0; dout still shows 0xFFFFFFFF combinationally.
REQ-030 Width edge case: IN_W=OUT_W=8, din=0x80 -> dout=0x80 for both ext_op=0 and ext_op=1.
